hd_tx: RTL and testbench

- Transmitter (source) end of the single-beat valid/ready handshake used by the HD register stage.
- Accepts a burst command (base value, beat count, inter-beat gap) and emits an incrementing data sequence on valid/data_src, obeying downstream backpressure on ready.
- Feeds an HD instance or any valid/ready sink. Replaces ad-hoc bench stimulus as the reusable traffic source.

---
 rtl/hd_tx.sv | 77 +++++++
 tb/tb_hd_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hd_tx.sv
// hd_tx: valid/ready burst source emitting an incrementing data sequence with optional inter-beat gaps.
module hd_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_src,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gcnt_q, gcnt_d;
  logic                  done_q, done_d;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = count != '0 ? SEND : IDLE;
        done_d  = count == '0;
        data_d  = count != '0 ? base : data_q;
        rem_d   = count;
        gap_d   = gap;
      end
      SEND: if (ready) begin
        // gap counts idle cycles, so GAP exits when the countdown reaches one
        state_d = rem_q == CNT_WIDTH'(1) ? IDLE : (gap_q == '0 ? SEND : GAP);
        done_d  = rem_q == CNT_WIDTH'(1);
        data_d  = rem_q == CNT_WIDTH'(1) ? data_q : data_q + DATA_WIDTH'(1);
        rem_d   = rem_q - CNT_WIDTH'(1);
        gcnt_d  = gap_q;
      end
      GAP: begin
        state_d = gcnt_q == GAP_WIDTH'(1) ? SEND : GAP;
        gcnt_d  = gcnt_q - GAP_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      done_q  <= done_d;
    end
  end
  assign valid    = state_q == SEND;
  assign busy     = state_q != IDLE;
  assign data_src = data_q;
  assign done     = done_q;
endmodule

// File: tb/tb_hd_tx.sv
// tb_hd_tx: scoreboard bench for hd_tx covering streaming, backpressure, gaps, wrap, and async reset.
module tb_hd_tx;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0;
  logic [15:0] base = '0;
  logic [7:0]  count = '0;
  logic [3:0]  gap = '0;
  logic        valid, busy, done;
  logic [15:0] data_src;
  int          checks = 0, errors = 0;
  logic [15:0] sb[$];
  logic [15:0] vcap, dcap, bcap;
  logic [15:0] dat[16];
  logic        pv = 1'b0, pr = 1'b0;
  logic [15:0] pd = '0;

  hd_tx dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count), .gap(gap),
    .ready(ready), .valid(valid), .data_src(data_src), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic monitor();
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (rst) pv = 1'b0;
      else begin
        if (pv && !pr) begin
          checks++;
          if (valid !== 1'b1 || data_src !== pd) begin
            errors++;
            $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", valid, data_src, pd);
          end
        end
        if (valid && ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected data=%h, scoreboard empty", data_src);
          end else begin
            exp = sb.pop_front();
            if (data_src !== exp) begin
              errors++;
              $display("FAIL beat: data=%h required %h", data_src, exp);
            end
          end
        end
        if (done) begin
          checks++;
          if (valid !== 1'b0) begin
            errors++;
            $display("FAIL done_valid: valid=%b required 0 during done", valid);
          end
        end
        pv = valid; pr = ready; pd = data_src;
      end
    end
  endtask

  task automatic start_burst(input logic [15:0] b, input logic [7:0] c, input logic [3:0] g);
    start = 1'b1; base = b; count = c; gap = g;
    for (int i = 0; i < int'(c); i++) sb.push_back(b + 16'(i));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_cycles(input int n, input logic [15:0] rp, input logic [15:0] sp);
    vcap = '0; dcap = '0; bcap = '0;
    for (int i = 0; i < n; i++) begin
      ready = rp[i];
      start = sp[i];
      if (sp[i]) begin base = 16'h0099; count = 8'd7; gap = 4'd0; end
      @(negedge clk);
      vcap[i] = valid; dcap[i] = done; bcap[i] = busy; dat[i] = data_src;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({valid, busy, done, data_src} !== 19'd0) begin
      errors++;
      $display("FAIL reset: v/b/d/data=%b%b%b/%h required all 0", valid, busy, done, data_src);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_stream();
    ready = 1'b1;
    start_burst(16'h0001, 8'd4, 4'd0);
    run_cycles(6, 16'hFFFF, 16'h0);
    checks++; if (vcap[5:0] !== 6'b001111) begin errors++; $display("FAIL t1_valid: got %b want 001111", vcap[5:0]); end
    checks++; if (dcap[5:0] !== 6'b010000) begin errors++; $display("FAIL t1_done: got %b want 010000", dcap[5:0]); end
    checks++; if (bcap[5:0] !== 6'b001111) begin errors++; $display("FAIL t1_busy: got %b want 001111", bcap[5:0]); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL t1_drain: %0d beats left want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    start_burst(16'h0010, 8'd3, 4'd0);
    run_cycles(10, 16'b11_1100_1000, 16'h0);
    checks++; if (vcap[9:0] !== 10'b00_1111_1111) begin errors++; $display("FAIL t2_valid: got %b want 0011111111", vcap[9:0]); end
    checks++; if (dcap[9:0] !== 10'b01_0000_0000) begin errors++; $display("FAIL t2_done: got %b want 0100000000", dcap[9:0]); end
    checks++; if (dat[2] !== 16'h0010) begin errors++; $display("FAIL t2_stall: data=%h want 0010", dat[2]); end
    checks++; if (dat[5] !== 16'h0011) begin errors++; $display("FAIL t2_stall2: data=%h want 0011", dat[5]); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL t2_drain: %0d beats left want 0", sb.size()); end
  endtask

  task automatic test_gap();
    ready = 1'b1;
    start_burst(16'h0005, 8'd3, 4'd2);
    run_cycles(8, 16'hFFFF, 16'h0);
    checks++; if (vcap[7:0] !== 8'b0100_1001) begin errors++; $display("FAIL t3_valid: got %b want 01001001", vcap[7:0]); end
    checks++; if (dcap[7:0] !== 8'b1000_0000) begin errors++; $display("FAIL t3_done: got %b want 10000000", dcap[7:0]); end
    checks++; if (bcap[7:0] !== 8'b0111_1111) begin errors++; $display("FAIL t3_busy: got %b want 01111111", bcap[7:0]); end
    checks++; if (dat[3] !== 16'h0006) begin errors++; $display("FAIL t3_data: data=%h want 0006", dat[3]); end
  endtask

  task automatic test_wrap_zero();
    ready = 1'b1;
    start_burst(16'hFFFE, 8'd3, 4'd0);
    run_cycles(5, 16'hFFFF, 16'h0);
    checks++; if (vcap[4:0] !== 5'b00111) begin errors++; $display("FAIL t4_wrap_valid: got %b want 00111", vcap[4:0]); end
    checks++; if (dat[2] !== 16'h0000) begin errors++; $display("FAIL t4_wrap_data: data=%h want 0000", dat[2]); end
    start_burst(16'h0123, 8'd0, 4'd0);
    run_cycles(3, 16'hFFFF, 16'h0);
    checks++; if (vcap[2:0] !== 3'b000) begin errors++; $display("FAIL t4_zero_valid: got %b want 000", vcap[2:0]); end
    checks++; if (dcap[2:0] !== 3'b001) begin errors++; $display("FAIL t4_zero_done: got %b want 001", dcap[2:0]); end
    checks++; if (bcap[2:0] !== 3'b000) begin errors++; $display("FAIL t4_zero_busy: got %b want 000", bcap[2:0]); end
  endtask

  task automatic test_ignored_start();
    ready = 1'b1;
    start_burst(16'h0020, 8'd4, 4'd1);
    run_cycles(9, 16'hFFFF, 16'b0000_0000_0000_0110);
    checks++; if (vcap[8:0] !== 9'b0_0101_0101) begin errors++; $display("FAIL t5_valid: got %b want 001010101", vcap[8:0]); end
    checks++; if (dcap[8:0] !== 9'b0_1000_0000) begin errors++; $display("FAIL t5_done: got %b want 010000000", dcap[8:0]); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL t5_drain: %0d beats left want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    start_burst(16'h0030, 8'd2, 4'd0);
    run_cycles(2, 16'hFFFF, 16'h0);
    checks++; if ({done, valid} !== 2'b10) begin errors++; $display("FAIL t5_b2b_done: done/valid=%b%b want 10", done, valid); end
    start_burst(16'h0040, 8'd2, 4'd0);
    run_cycles(3, 16'hFFFF, 16'h0);
    checks++; if (vcap[2:0] !== 3'b011) begin errors++; $display("FAIL t5_b2b_valid: got %b want 011", vcap[2:0]); end
    checks++; if (dcap[2:0] !== 3'b100) begin errors++; $display("FAIL t5_b2b_done2: got %b want 100", dcap[2:0]); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL t5_b2b_drain: %0d beats left want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    start_burst(16'h0050, 8'd5, 4'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({valid, busy, data_src} !== 18'd0) begin
      errors++;
      $display("FAIL t6_async: v/b/data=%b%b/%h required 0/0/0000", valid, busy, data_src);
    end
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    run_cycles(3, 16'hFFFF, 16'h0);
    checks++; if (dcap[2:0] !== 3'b000) begin errors++; $display("FAIL t6_nodone: got %b want 000", dcap[2:0]); end
    checks++; if (vcap[2:0] !== 3'b000) begin errors++; $display("FAIL t6_idle: got %b want 000", vcap[2:0]); end
    start_burst(16'h0001, 8'd4, 4'd0);
    run_cycles(6, 16'hFFFF, 16'h0);
    checks++; if (vcap[5:0] !== 6'b001111) begin errors++; $display("FAIL t6_valid: got %b want 001111", vcap[5:0]); end
    checks++; if (dcap[5:0] !== 6'b010000) begin errors++; $display("FAIL t6_done: got %b want 010000", dcap[5:0]); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL t6_drain: %0d beats left want 0", sb.size()); end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_gap();
    test_wrap_zero();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
